// File: rtl/snake_move_ctrl_if.sv
// Purpose: bundle of the snake controller's control, status and segment-read signals.
// Latency: none (wires only).
// Backpressure: none; the controller consumes levels and produces levels or pulses.
// Ports (signals):
//   start, left, right, up, down   master->slave  level controls.
//   food_x, food_y                 master->slave  current food cell.
//   rd_idx                         master->slave  renderer segment index.
//   food_eaten, game_over          slave->master  status.
//   head_x, head_y, snake_len      slave->master  head cell and body length.
//   rd_x, rd_y, rd_valid           slave->master  combinational segment read.
interface snake_move_ctrl_if;
  logic       start;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic [5:0] food_x;
  logic [5:0] food_y;
  logic       food_eaten;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [6:0] snake_len;
  logic       game_over;
  logic [6:0] rd_idx;
  logic [5:0] rd_x;
  logic [5:0] rd_y;
  logic       rd_valid;

  modport master (
    output start, left, right, up, down, food_x, food_y, rd_idx,
    input  food_eaten, head_x, head_y, snake_len, game_over, rd_x, rd_y, rd_valid
  );

  modport slave (
    input  start, left, right, up, down, food_x, food_y, rd_idx,
    output food_eaten, head_x, head_y, snake_len, game_over, rd_x, rd_y, rd_valid
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// Purpose: snake body registers, per-tick move with wrap, growth on food, self-collision scan.
// Latency: one move every TICK_DIV cycles; head/len update at end of SHIFT; scan takes len-1 cycles.
// Backpressure: none; buttons are sampled every running cycle, read port is combinational.
// Ports: clk_i (rising edge), rst_i (async, active high), bus (snake_move_ctrl_if.slave).
module snake_move_ctrl #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 64,
  parameter int TICK_DIV = 5000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  snake_move_ctrl_if.slave  bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [5:0] XMAX = 6'(GRID_W - 1);
  localparam logic [5:0] YMAX = 6'(GRID_H - 1);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SHIFT, S_CHECK, S_OVER} state_e;
  // Encoding chosen so the opposite direction is dir ^ 1.
  typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_e;

  state_e         state_q;
  dir_e           dir_q, pend_q, pend_d, req;
  logic [CW-1:0]  cnt_q;
  logic [6:0]     len_q;
  logic [IW-1:0]  chk_q;
  logic [5:0]     seg_x_q [MAX_LEN];
  logic [5:0]     seg_y_q [MAX_LEN];
  logic [5:0]     nh_x_q, nh_y_q, nx, ny;
  logic           food_eaten_q, game_over_q;
  logic           running, req_vld, hit, tick_end;
  logic [IW-1:0]  rd_sel;

  function automatic logic [5:0] init_x(int k);
    return (k < 3) ? 6'(GRID_W / 2 - k) : 6'd0;
  endfunction

  function automatic logic [5:0] init_y(int k);
    return (k < 3) ? 6'(GRID_H / 2) : 6'd0;
  endfunction

  assign running  = (state_q == S_RUN) || (state_q == S_SHIFT) || (state_q == S_CHECK);
  assign tick_end = (cnt_q == CW'(TICK_DIV - 1));

  // Direction latch and candidate head. The head is computed from pend_d on the
  // last RUN cycle, which is exactly the pend value SHIFT sees, so food_eaten
  // can be registered and be high during SHIFT itself.
  always_comb begin
    req_vld = bus.left | bus.right | bus.up | bus.down;
    req     = D_DOWN;
    if (bus.left)       req = D_LEFT;
    else if (bus.right) req = D_RIGHT;
    else if (bus.up)    req = D_UP;
    pend_d = pend_q;
    if (running && req_vld && (req != dir_e'(dir_q ^ 2'b01)))
      pend_d = req;

    nx = seg_x_q[0];
    ny = seg_y_q[0];
    case (pend_d)
      D_LEFT:  nx = (seg_x_q[0] == 6'd0) ? XMAX : seg_x_q[0] - 6'd1;
      D_RIGHT: nx = (seg_x_q[0] == XMAX) ? 6'd0 : seg_x_q[0] + 6'd1;
      D_UP:    ny = (seg_y_q[0] == 6'd0) ? YMAX : seg_y_q[0] - 6'd1;
      default: ny = (seg_y_q[0] == YMAX) ? 6'd0 : seg_y_q[0] + 6'd1;
    endcase
    hit = (nx == bus.food_x) && (ny == bus.food_y);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      dir_q        <= D_RIGHT;
      pend_q       <= D_RIGHT;
      cnt_q        <= '0;
      len_q        <= 7'd3;
      chk_q        <= IW'(1);
      nh_x_q       <= '0;
      nh_y_q       <= '0;
      food_eaten_q <= 1'b0;
      game_over_q  <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= init_x(k);
        seg_y_q[k] <= init_y(k);
      end
    end else begin
      food_eaten_q <= 1'b0;
      if (running) begin
        pend_q <= pend_d;
        cnt_q  <= tick_end ? '0 : cnt_q + CW'(1);
      end
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.start) state_q <= S_RUN;
        end
        S_RUN: begin
          if (tick_end) begin
            state_q      <= S_SHIFT;
            nh_x_q       <= nx;
            nh_y_q       <= ny;
            food_eaten_q <= hit;
          end
        end
        S_SHIFT: begin
          for (int k = 1; k < MAX_LEN; k++) begin
            seg_x_q[k] <= seg_x_q[k-1];
            seg_y_q[k] <= seg_y_q[k-1];
          end
          seg_x_q[0] <= nh_x_q;
          seg_y_q[0] <= nh_y_q;
          dir_q      <= pend_q;
          // The old tail already sits at index len after the shift, so growing
          // just widens the window.
          if (food_eaten_q && (len_q != LEN_MAX)) len_q <= len_q + 7'd1;
          chk_q   <= IW'(1);
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if ((seg_x_q[chk_q] == seg_x_q[0]) && (seg_y_q[chk_q] == seg_y_q[0])) begin
            state_q     <= S_OVER;
            game_over_q <= 1'b1;
            cnt_q       <= '0;
          end else if (7'(chk_q) == len_q - 7'd1) begin
            state_q <= S_RUN;
          end else begin
            chk_q <= chk_q + IW'(1);
          end
        end
        S_OVER: begin
          cnt_q <= '0;
          if (bus.start) begin
            state_q     <= S_RUN;
            game_over_q <= 1'b0;
            dir_q       <= D_RIGHT;
            pend_q      <= D_RIGHT;
            len_q       <= 7'd3;
            for (int k = 0; k < MAX_LEN; k++) begin
              seg_x_q[k] <= init_x(k);
              seg_y_q[k] <= init_y(k);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_sel = bus.rd_idx[IW-1:0];

  always_comb begin
    bus.rd_valid = (bus.rd_idx < len_q);
    bus.rd_x     = 6'd0;
    bus.rd_y     = 6'd0;
    if (bus.rd_valid) begin
      bus.rd_x = seg_x_q[rd_sel];
      bus.rd_y = seg_y_q[rd_sel];
    end
  end

  assign bus.food_eaten = food_eaten_q;
  assign bus.game_over  = game_over_q;
  assign bus.head_x     = seg_x_q[0];
  assign bus.head_y     = seg_y_q[0];
  assign bus.snake_len  = len_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Purpose: directed, table-driven check of snake_move_ctrl moves, growth, collision and reset.
// Latency: one table row per game tick (8 cycles).
// Backpressure: not applicable.
module tb_snake_move_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  snake_move_ctrl_if bus ();

  snake_move_ctrl #(
    .GRID_W(32), .GRID_H(24), .MAX_LEN(5), .TICK_DIV(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b0;    // {left,right,up,down} during first cycle of the tick
    logic [3:0] b1;    // second cycle
    logic [5:0] fx, fy;
    logic [6:0] ridx;
    logic       eat;
    logic [5:0] ex, ey;
    logic [6:0] elen;
    logic [5:0] erx, ery;
    logic       erv;
  } vec_t;

  localparam logic [3:0] BN = 4'b0000, BL = 4'b1000, BR = 4'b0100, BU = 4'b0010, BD = 4'b0001;

  vec_t tbl [9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {bus.left, bus.right, bus.up, bus.down} = b;
  endtask

  // Starts at a negedge: either the first RUN cycle after start (first=1) or
  // the first CHECK cycle of the previous tick. Ends on the first CHECK cycle.
  task automatic apply_tick(input vec_t v, input bit first, input string tag);
    bus.food_x = v.fx;
    bus.food_y = v.fy;
    bus.rd_idx = v.ridx;
    set_btn(v.b0);
    @(negedge clk);
    set_btn(v.b1);
    @(negedge clk);
    set_btn(BN);
    repeat (first ? 6 : 5) @(negedge clk);
    chk({tag, " eat_in_shift"}, int'(bus.food_eaten), int'(v.eat));
    @(negedge clk);
    chk({tag, " eat_cleared"}, int'(bus.food_eaten), 0);
    chk({tag, " head_x"}, int'(bus.head_x), int'(v.ex));
    chk({tag, " head_y"}, int'(bus.head_y), int'(v.ey));
    chk({tag, " len"}, int'(bus.snake_len), int'(v.elen));
    chk({tag, " rd_valid"}, int'(bus.rd_valid), int'(v.erv));
    chk({tag, " rd_x"}, int'(bus.rd_x), int'(v.erx));
    chk({tag, " rd_y"}, int'(bus.rd_y), int'(v.ery));
  endtask

  initial begin
    vec_t w;
    //          b0  b1  fx  fy  ridx eat ex  ey  len rx  ry  rv
    tbl[0] = '{BN, BN, 17, 12, 3, 1, 17, 12, 4, 14, 12, 1};  // eat, grow, old tail kept
    tbl[1] = '{BL, BN, 63, 63, 4, 0, 18, 12, 4,  0,  0, 0};  // reverse ignored
    tbl[2] = '{BU, BL, 63, 63, 1, 0, 18, 11, 4, 18, 12, 1};  // up then left: up wins
    tbl[3] = '{BN, BN, 63, 63, 3, 0, 18, 10, 4, 17, 12, 1};  // committed dir is UP
    tbl[4] = '{BN, BN, 18,  9, 4, 1, 18,  9, 5, 17, 12, 1};  // grow to MAX_LEN
    tbl[5] = '{BR, BN, 19,  9, 4, 1, 19,  9, 5, 18, 12, 1};  // eat at max: len held
    tbl[6] = '{BU, BN, 63, 63, 2, 0, 19,  8, 5, 18,  9, 1};
    tbl[7] = '{BL, BN, 63, 63, 1, 0, 18,  8, 5, 19,  8, 1};
    tbl[8] = '{BD, BN, 63, 63, 4, 0, 18,  9, 5, 18,  9, 1};  // head lands on seg4

    bus.start = 1'b0;
    set_btn(BN);
    bus.food_x = 6'd63;
    bus.food_y = 6'd63;
    bus.rd_idx = 7'd2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst head_x", int'(bus.head_x), 16);
    chk("rst head_y", int'(bus.head_y), 12);
    chk("rst len", int'(bus.snake_len), 3);
    chk("rst game_over", int'(bus.game_over), 0);
    chk("rst food_eaten", int'(bus.food_eaten), 0);
    chk("rst rd2_x", int'(bus.rd_x), 14);
    chk("rst rd2_valid", int'(bus.rd_valid), 1);
    bus.rd_idx = 7'd3;
    #1;
    chk("rst rd3_valid", int'(bus.rd_valid), 0);
    chk("rst rd3_x", int'(bus.rd_x), 0);

    // IDLE must not move without start.
    repeat (12) @(negedge clk);
    chk("idle head_x", int'(bus.head_x), 16);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++)
      apply_tick(tbl[i], i == 0, $sformatf("vec%0d", i));

    // Collision scan: CHECK i=1..4, match at i=4, OVER the cycle after.
    chk("scan i1 game_over", int'(bus.game_over), 0);
    repeat (3) @(negedge clk);
    chk("scan i4 game_over", int'(bus.game_over), 0);
    @(negedge clk);
    chk("over game_over", int'(bus.game_over), 1);

    // Frozen in OVER, buttons ignored.
    set_btn(BU);
    repeat (20) @(negedge clk);
    set_btn(BN);
    chk("frozen head_x", int'(bus.head_x), 18);
    chk("frozen head_y", int'(bus.head_y), 9);
    chk("frozen len", int'(bus.snake_len), 5);
    chk("frozen game_over", int'(bus.game_over), 1);

    // Restart.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rd_idx = 7'd2;
    #1;
    chk("restart len", int'(bus.snake_len), 3);
    chk("restart head_x", int'(bus.head_x), 16);
    chk("restart head_y", int'(bus.head_y), 12);
    chk("restart game_over", int'(bus.game_over), 0);
    chk("restart rd2_x", int'(bus.rd_x), 14);

    // Straight run to the right edge and wrap to x=0.
    for (int k = 1; k <= 17; k++) begin
      w = '{BN, BN, 63, 63, 0, 0, 6'((16 + k) % 32), 12, 3, 6'((16 + k) % 32), 12, 1};
      apply_tick(w, k == 1, $sformatf("wrap%0d", k));
    end

    // Async reset in the middle of a CHECK cycle.
    #2 rst = 1'b1;
    #1;
    chk("arst len", int'(bus.snake_len), 3);
    chk("arst head_x", int'(bus.head_x), 16);
    chk("arst game_over", int'(bus.game_over), 0);
    chk("arst food_eaten", int'(bus.food_eaten), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("arst idle head_x", int'(bus.head_x), 16);
    chk("arst idle len", int'(bus.snake_len), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
